player_input: RTL

Upstream control stage for the Tron display path. Synchronizes and debounces both players' raw direction buttons, rejects illegal turns, and runs the game run/halt state machine. Once per frame it presents a 4-bit `p1_info` / `p2_info` word, which the object-drawing stage consumes at the same bottom-right-pixel frame boundary.

---
 rtl/player_input.sv | 136 +++++++++++++
 1 files changed

// File: rtl/player_input.sv
// Player input front end for the Tron display path: button sync/debounce, turn
// legality filtering, run/halt FSM and per-frame {restart, move, dir} words.
module player_input #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] row,
  input  logic [9:0] col,
  input  logic [3:0] p1_btn,
  input  logic [3:0] p2_btn,
  input  logic       start,
  input  logic       game_over,
  output logic [3:0] p1_info,
  output logic [3:0] p2_info,
  output logic       frame_tick,
  output logic [1:0] state
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10} state_t;

  state_t           st, st_nxt;
  logic [7:0]       sync_p0, sync_p1, db_p2, db_q;
  logic [CNT_W-1:0] cnt [8];
  logic [1:0]       dir [2];
  logic [1:0]       pend_dir [2];
  logic [1:0]       pend_vld;
  logic             restart;
  logic             fb, move, reload;
  logic [2:0]       pk [2];
  logic [1:0]       req_ok;

  // {valid, dir}: up > right > down > left when several edges coincide
  function automatic logic [2:0] pick_req(input logic [3:0] r);
    if (r[0])      return 3'b100;
    else if (r[1]) return 3'b101;
    else if (r[2]) return 3'b110;
    else if (r[3]) return 3'b111;
    else           return 3'b000;
  endfunction

  // Only a quarter turn is legal: same (xor 00) and reverse (xor 10) are dropped
  function automatic logic is_legal(input logic [1:0] req, input logic [1:0] cur);
    logic [1:0] x;
    x = req ^ cur;
    return x[0];
  endfunction

  assign fb     = (row == 10'd599) && (col == 10'd799);
  assign move   = (st == RUN);
  assign reload = start && (st == IDLE || st == HALT);

  assign pk[0]     = pick_req(db_p2[3:0] & ~db_q[3:0]);
  assign pk[1]     = pick_req(db_p2[7:4] & ~db_q[7:4]);
  assign req_ok[0] = pk[0][2] && is_legal(pk[0][1:0], dir[0]);
  assign req_ok[1] = pk[1][2] && is_legal(pk[1][1:0], dir[1]);

  // Stage p0/p1: two-flop synchronizer; stage p2: debounced level
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      db_p2   <= '0;
      db_q    <= '0;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      sync_p0 <= {p2_btn, p1_btn};
      sync_p1 <= sync_p0;
      db_q    <= db_p2;
      for (int i = 0; i < 8; i++) begin
        if (sync_p1[i] != db_p2[i]) begin
          if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db_p2[i] <= sync_p1[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st          <= IDLE;
      dir[0]      <= 2'b00;
      dir[1]      <= 2'b10;
      pend_dir[0] <= 2'b00;
      pend_dir[1] <= 2'b00;
      pend_vld    <= 2'b00;
      restart     <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      st         <= st_nxt;
      frame_tick <= fb;
      if (fb) restart <= 1'b0;
      if (reload) begin
        dir[0]   <= 2'b00;
        dir[1]   <= 2'b10;
        pend_vld <= 2'b00;
        restart  <= 1'b1;
      end else if (st == RUN && !game_over) begin
        // A request landing on fb is queued after the old one is applied
        for (int p = 0; p < 2; p++) begin
          if (fb && !restart && pend_vld[p]) dir[p] <= pend_dir[p];
          if (req_ok[p]) begin
            pend_vld[p] <= 1'b1;
            pend_dir[p] <= pk[p][1:0];
          end else if (fb && !restart) begin
            pend_vld[p] <= 1'b0;
          end
        end
      end else begin
        pend_vld <= 2'b00;
      end
    end
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (start)     st_nxt = RUN;
      RUN:     if (game_over) st_nxt = HALT;
      HALT:    if (start)     st_nxt = RUN;
      default: st_nxt = IDLE;
    endcase
  end

  assign p1_info = {restart, move, dir[0]};
  assign p2_info = {restart, move, dir[1]};
  assign state   = st;

endmodule
